// File: rtl/multiplier_nbit_seq_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM state encoding
// and the iteration-counter width helper.
package multiplier_nbit_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must index WIDTH iterations; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/multiplier_nbit_seq_adder.sv
// Generic WIDTH-bit adder with carry-in; IMPL_TYPE selects a behavioural adder (0)
// or an explicit ripple-carry chain (any other value).
module adder_nbit_cin #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned IMPL_TYPE = 0
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);

   generate
      if (IMPL_TYPE == 0) begin : g_behav
         assign {o_cout, o_sum} = (WIDTH+1)'(i_a) + (WIDTH+1)'(i_b) + (WIDTH+1)'(i_cin);
      end else begin : g_ripple
         logic [WIDTH:0] w_c;
         assign w_c[0] = i_cin;
         for (genvar g = 0; g < WIDTH; g++) begin : g_bit
            assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
            assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
         end
         assign o_cout = w_c[WIDTH];
      end
   endgenerate

endmodule

// File: rtl/multiplier_nbit_seq.sv
// Iterative shift-add unsigned multiplier: one shared 2*WIDTH adder reused over
// WIDTH cycles, with valid/ready handshakes on operands and product.
module multiplier_nbit_seq
   import multiplier_nbit_seq_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned IMPL_TYPE = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   P,
   output logic                 busy
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [PW-1:0]    r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [PW-1:0]    r_acc;
   logic [CW-1:0]    r_cnt;
   logic [PW-1:0]    r_p;

   logic [PW-1:0]    w_sum;
   logic             w_unused_cout;
   logic [PW-1:0]    w_acc_next;
   logic             w_last;

   adder_nbit_cin #(
      .WIDTH     (PW),
      .IMPL_TYPE (IMPL_TYPE)
   ) u_adder (
      .i_a    (r_acc),
      .i_b    (r_mcand),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_unused_cout)
   );

   assign w_acc_next = r_mplier[0] ? w_sum : r_acc;
   assign w_last     = (r_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_next = RUN;
         RUN:     if (w_last)    w_state_next = DONE;
         DONE:    if (out_ready) w_state_next = IDLE;
         default:                w_state_next = IDLE;
      endcase
   end

   // Operand shift registers, accumulator, iteration counter and product register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_p      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_mcand  <= PW'(A);
                  r_mplier <= B;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            RUN: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
                  r_p <= w_acc_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign out_valid = (r_state == DONE);
   assign P         = r_p;

endmodule

// File: tb/tb_multiplier_nbit_seq.sv
// Scoreboard bench for multiplier_nbit_seq: an 8-bit and a 32-bit (ripple adder) instance,
// expected products from plain multiplication, checked by independent monitors.
module tb_multiplier_nbit_seq;

   typedef struct {
      logic [63:0] p;
      int          edge_n;
   } exp_t;

   logic        clk = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   logic        rst8, iv8, ir8, ov8, busy8, rdy_fix8, rand_mode, rdy_rand;
   logic        ordy8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        ov8_q = 1'b0;
   exp_t        q8[$];

   logic        rst32, iv32, ir32, ov32, busy32, ordy32;
   logic [31:0] a32, b32;
   logic [63:0] p32;
   logic        ov32_q = 1'b0;
   exp_t        q32[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rdy_rand <= 1'($urandom);
   assign ordy8 = rand_mode ? rdy_rand : rdy_fix8;

   multiplier_nbit_seq #(.WIDTH(8), .IMPL_TYPE(0)) u_dut8 (
      .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
      .out_valid(ov8), .out_ready(ordy8), .P(p8), .busy(busy8)
   );

   multiplier_nbit_seq #(.WIDTH(32), .IMPL_TYPE(1)) u_dut32 (
      .clk(clk), .rst(rst32), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
      .out_valid(ov32), .out_ready(ordy32), .P(p32), .busy(busy32)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor for the 8-bit instance: latency and value at out_valid rise, value at handshake.
   always @(negedge clk) begin
      #2;
      if (rst8) begin
         ov8_q = 1'b0;
      end else begin
         if (ov8 && !ov8_q) begin
            if (q8.size() == 0) chk("unexpected_out8", 64'(p8), 64'hDEAD);
            else begin
               chk("latency8", 64'(cyc - q8[0].edge_n), 64'd8);
               chk("p8_valid", 64'(p8), q8[0].p);
            end
         end
         if (ov8 && ordy8 && q8.size() != 0) begin
            chk("p8_handshake", 64'(p8), q8[0].p);
            void'(q8.pop_front());
         end
         ov8_q = ov8;
      end
   end

   always @(negedge clk) begin
      #2;
      if (rst32) begin
         ov32_q = 1'b0;
      end else begin
         if (ov32 && !ov32_q) begin
            if (q32.size() == 0) chk("unexpected_out32", p32, 64'hDEAD);
            else begin
               chk("latency32", 64'(cyc - q32[0].edge_n), 64'd32);
               chk("p32_valid", p32, q32[0].p);
            end
         end
         if (ov32 && ordy32 && q32.size() != 0) begin
            chk("p32_handshake", p32, q32[0].p);
            void'(q32.pop_front());
         end
         ov32_q = ov32;
      end
   end

   // Called at a negedge; returns at the negedge following the accept edge.
   task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit keep, output int edge_n);
      a8 = a; b8 = b; iv8 = 1'b1; edge_n = -1;
      for (int i = 0; i < 300; i++) begin
         if (ir8) begin
            edge_n = cyc + 1;
            q8.push_back('{p: 64'(a) * 64'(b), edge_n: edge_n});
            @(negedge clk);
            if (!keep) iv8 = 1'b0;
            return;
         end
         @(negedge clk);
      end
      iv8 = 1'b0;
      chk("accept_timeout8", 64'd0, 64'd1);
   endtask

   task automatic send32(input logic [31:0] a, input logic [31:0] b);
      a32 = a; b32 = b; iv32 = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (ir32) begin
            q32.push_back('{p: 64'(a) * 64'(b), edge_n: cyc + 1});
            @(negedge clk);
            iv32 = 1'b0;
            return;
         end
         @(negedge clk);
      end
      iv32 = 1'b0;
      chk("accept_timeout32", 64'd0, 64'd1);
   endtask

   task automatic drain8();
      for (int i = 0; i < 500 && q8.size() != 0; i++) @(negedge clk);
      chk("drain8", 64'(q8.size()), 64'd0);
   endtask

   task automatic drain32();
      for (int i = 0; i < 500 && q32.size() != 0; i++) @(negedge clk);
      chk("drain32", 64'(q32.size()), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e1, e2, e3;
      rst8 = 1'b1; rst32 = 1'b1; iv8 = 1'b0; iv32 = 1'b0;
      a8 = '0; b8 = '0; a32 = '0; b32 = '0;
      rdy_fix8 = 1'b1; rand_mode = 1'b0; ordy32 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(ir8), 64'd1);
      chk("rst_out_valid", 64'(ov8), 64'd0);
      chk("rst_p", 64'(p8), 64'd0);
      chk("rst_busy", 64'(busy8), 64'd0);
      chk("rst_p32", p32, 64'd0);
      rst8 = 1'b0; rst32 = 1'b0;
      @(negedge clk);

      // Basic products and zero operands with full latency
      send8(8'd13, 8'd11, 1'b0, e1);
      drain8();
      chk("in_ready_after_done", 64'(ir8), 64'd1);
      chk("busy_after_done", 64'(busy8), 64'd0);
      send8(8'd255, 8'd255, 1'b0, e1); drain8();
      send8(8'd0, 8'd200, 1'b0, e1);   drain8();
      send8(8'd77, 8'd0, 1'b0, e1);    drain8();

      // Backpressure: product held, new operands ignored
      rdy_fix8 = 1'b0;
      send8(8'd6, 8'd7, 1'b0, e1);
      for (int i = 0; i < 50 && !ov8; i++) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         chk("bp_out_valid", 64'(ov8), 64'd1);
         chk("bp_p", 64'(p8), 64'd42);
         chk("bp_in_ready", 64'(ir8), 64'd0);
         iv8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
         @(negedge clk);
      end
      iv8 = 1'b0; rdy_fix8 = 1'b1;
      drain8();

      // Back-to-back with in_valid held high
      send8(8'd3, 8'd5, 1'b1, e1);
      send8(8'd100, 8'd2, 1'b1, e2);
      send8(8'd9, 8'd9, 1'b0, e3);
      chk("b2b_ii_1", 64'(e2 - e1), 64'd10);
      chk("b2b_ii_2", 64'(e3 - e2), 64'd10);
      drain8();

      // Abort mid-RUN, then a normal operation
      send8(8'd50, 8'd50, 1'b0, e1);
      repeat (4) @(negedge clk);
      rst8 = 1'b1;
      #1;
      chk("abort_out_valid", 64'(ov8), 64'd0);
      chk("abort_p", 64'(p8), 64'd0);
      chk("abort_busy", 64'(busy8), 64'd0);
      chk("abort_in_ready", 64'(ir8), 64'd1);
      q8.delete();
      @(negedge clk);
      rst8 = 1'b0;
      @(negedge clk);
      send8(8'd2, 8'd3, 1'b0, e1); drain8();

      // Random operands, random consumer stalls, operands disturbed during RUN
      rand_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send8(8'($urandom), 8'($urandom), 1'($urandom), e1);
         a8 = 8'($urandom); b8 = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            iv8 = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
         end
      end
      iv8 = 1'b0;
      drain8();
      rand_mode = 1'b0;

      // Wide instance with ripple adder
      send32(32'hFFFF_FFFF, 32'hFFFF_FFFF); drain32();
      send32(32'd0, 32'hDEAD_BEEF);        drain32();
      for (int i = 0; i < 8; i++) begin
         send32($urandom, $urandom);
         drain32();
      end

      repeat (5) @(negedge clk);
      chk("final_q8_empty", 64'(q8.size()), 64'd0);
      chk("final_q32_empty", 64'(q32.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
